// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer slice.
// Holds the default widths/sizes and the starve FSM state encoding.
package store_buffer_pkg;
  localparam int SB_W            = 16;
  localparam int SB_DEPTH        = 4;
  localparam int SB_MATCH_W      = 3;
  localparam int SB_STARVE_LIMIT = 8;

  // RUN: loads have priority over drains.
  // FORCE: one drain is forced ahead of any load.
  typedef enum logic {
    RUN   = 1'b0,
    FORCE = 1'b1
  } sb_state_e;
endpackage

// File: rtl/store_buffer_if.sv
// Bus bundle between the MEM stage, the store buffer and the data memory.
// slave  : the store buffer (takes CPU requests and mem_rdata, drives
//          cpu_rdata/cpu_stall/sb_empty and the memory port).
// master : the environment (MEM stage plus data memory).
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int W = SB_W
);
  logic [W-1:0] cpu_addr;
  logic [W-1:0] cpu_wdata;
  logic         cpu_we;
  logic         cpu_re;
  logic         cpu_fence;
  logic [W-1:0] cpu_rdata;
  logic         cpu_stall;
  logic         sb_empty;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_we;
  logic         mem_re;
  logic [W-1:0] mem_rdata;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, cpu_fence, mem_rdata,
    output cpu_rdata, cpu_stall, sb_empty, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, cpu_fence, mem_rdata,
    input  cpu_rdata, cpu_stall, sb_empty, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/store_buffer_sb_fifo.sv
// In-order entry storage for the store buffer.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push, push_addr/data  enqueue at the tail (ignored when full)
//   pop                   dequeue the head (ignored when empty)
//   head_addr/head_data   oldest entry
//   tail, count           write pointer and occupancy (count has one extra
//                         bit so full and empty are distinct)
//   full, empty           occupancy flags
//   ent_addr/ent_data     flat view of every slot for the forwarding search
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int W     = SB_W,
  parameter int DEPTH = SB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              push_addr,
  input  logic [W-1:0]              push_data,
  output logic [W-1:0]              head_addr,
  output logic [W-1:0]              head_data,
  output logic [PTR_W-1:0]          tail,
  output logic [CNT_W-1:0]          count,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH-1:0][W-1:0]   ent_addr,
  output logic [DEPTH-1:0][W-1:0]   ent_data
);
  logic [PTR_W-1:0] head;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (pop_ok)  head <= head + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
    end
  end

  // Entry payload carries no reset; only slots below count are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      ent_addr[tail] <= push_addr;
      ent_data[tail] <= push_data;
    end
  end

  assign head_addr = ent_addr[head];
  assign head_data = ent_data[head];
endmodule

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a data memory with combinational
// read / synchronous write. Stores queue in order and drain in any cycle
// without a serviced load; loads forward from the youngest matching entry.
// A starve counter forces a drain ahead of loads after a run of blocked
// drains, and a fence drains everything before completing.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  store_buffer_if.slave: cpu_* request/response and mem_* port
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int W            = SB_W,
  parameter int DEPTH        = SB_DEPTH,
  parameter int MATCH_W      = SB_MATCH_W,
  parameter int STARVE_LIMIT = SB_STARVE_LIMIT
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT) + 1;

  logic [W-1:0]            head_addr;
  logic [W-1:0]            head_data;
  logic [PTR_W-1:0]        tail;
  logic [CNT_W-1:0]        count;
  logic                    full;
  logic                    empty;
  logic [DEPTH-1:0][W-1:0] ent_addr;
  logic [DEPTH-1:0][W-1:0] ent_data;

  sb_state_e        state;
  logic [STV_W-1:0] starve;

  logic             do_fence;
  logic             do_store;
  logic             do_load;
  logic             load_ok;
  logic             drain;
  logic             push;
  logic             stall_c;

  logic             fwd_hit;
  logic [W-1:0]     fwd_data;
  logic [PTR_W-1:0] idx;

  function automatic logic low_match(input logic [MATCH_W-1:0] a,
                                     input logic [MATCH_W-1:0] b);
    return a == b;
  endfunction

  sb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (drain),
    .push_addr (bus.cpu_addr),
    .push_data (bus.cpu_wdata),
    .head_addr (head_addr),
    .head_data (head_data),
    .tail      (tail),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data)
  );

  // Request decode: fence > store > load; lower requests are dropped.
  always_comb begin
    do_fence = bus.cpu_fence;
    do_store = !bus.cpu_fence && bus.cpu_we;
    do_load  = !bus.cpu_fence && !bus.cpu_we && bus.cpu_re;
    load_ok  = do_load && (state == RUN);
    drain    = !empty && !load_ok;
    push     = do_store && !full;
    stall_c  = (do_fence && !empty) || (do_store && full) ||
               (do_load && (state == FORCE));
  end

  // Youngest-first scan starting at tail-1; first hit wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail - PTR_W'(i + 1);
      if (!fwd_hit && (CNT_W'(i) < count) &&
          low_match(ent_addr[idx][MATCH_W-1:0], bus.cpu_addr[MATCH_W-1:0])) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end

  // Port muxing. rst masks everything so outputs reach their reset values
  // immediately, even if the MEM stage keeps requesting during reset.
  always_comb begin
    bus.cpu_stall = 1'b0;
    bus.cpu_rdata = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    if (!rst) begin
      bus.cpu_stall = stall_c;
      if (load_ok) begin
        bus.mem_re    = 1'b1;
        bus.mem_addr  = bus.cpu_addr;
        bus.cpu_rdata = fwd_hit ? fwd_data : bus.mem_rdata;
      end else if (drain) begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = head_addr;
        bus.mem_wdata = head_data;
      end
    end
  end

  assign bus.sb_empty = empty;

  // Starve FSM: counts loads that block a pending drain; the blocked cycle
  // seen with the counter at STARVE_LIMIT-1 arms FORCE for the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      starve <= '0;
    end else begin
      case (state)
        RUN: begin
          if (load_ok && !empty) begin
            if (starve == STV_W'(STARVE_LIMIT - 1)) state <= FORCE;
            starve <= starve + STV_W'(1);
          end else begin
            starve <= '0;
          end
        end
        FORCE: begin
          state  <= RUN;
          starve <= '0;
        end
        default: begin
          state  <= RUN;
          starve <= '0;
        end
      endcase
    end
  end
endmodule
